// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - registered VGA raster timing generator with pixel clock-enable.
// Optional VGA_TIMING_FRAME_COUNT_EN adds an 8-bit frame_count output.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       de,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
  endgenerate

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HB_START = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VB_START = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       de_q, de_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [10:0] h_ext, v_ext;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;
`endif

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (ce_pix) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = 10'd0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end

    // Decode from the next counts so every registered output describes the same pixel.
    h_ext    = {1'b0, hcount_d};
    v_ext    = {1'b0, vcount_d};
    hblank_d = (h_ext >= HB_START);
    vblank_d = (v_ext >= VB_START);
    de_d     = ~hblank_d & ~vblank_d;
    hsync_d  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      frame_count_q <= 8'd0;
`endif
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef VGA_TIMING_FRAME_COUNT_EN
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen.
// Instance a uses 640x480 defaults; instance b is a 16x10 raster for whole-frame runs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce_a, ce_b;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic       a_hs, a_vs, a_hb, a_vb, a_de, a_ls, a_fs;
  logic       b_hs, b_vs, b_hb, b_vb, b_de, b_ls, b_fs;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] a_fc, b_fc;
`endif

  vga_timing_gen u_a (
    .clk(clk), .reset(reset), .ce_pix(ce_a),
    .hcount(a_h), .vcount(a_v), .hsync(a_hs), .vsync(a_vs),
    .hblank(a_hb), .vblank(a_vb), .de(a_de),
    .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0)
  ) u_b (
    .clk(clk), .reset(reset), .ce_pix(ce_b),
    .hcount(b_h), .vcount(b_v), .hsync(b_hs), .vsync(b_vs),
    .hblank(b_hb), .vblank(b_vb), .de(b_de),
    .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  int ma_h, ma_v, mb_h, mb_v, mb_fc;
  bit ma_ls, ma_fs, mb_ls, mb_fs;

  task automatic check_a();
    check("a_hcount", 32'(a_h), ma_h);
    check("a_vcount", 32'(a_v), ma_v);
    check("a_hsync", 32'(a_hs), (ma_h >= 656 && ma_h < 752) ? 0 : 1);
    check("a_vsync", 32'(a_vs), (ma_v >= 490 && ma_v < 492) ? 0 : 1);
    check("a_hblank", 32'(a_hb), (ma_h >= 640) ? 1 : 0);
    check("a_vblank", 32'(a_vb), (ma_v >= 480) ? 1 : 0);
    check("a_de", 32'(a_de), (ma_h < 640 && ma_v < 480) ? 1 : 0);
    check("a_line_start", 32'(a_ls), 32'(ma_ls));
    check("a_frame_start", 32'(a_fs), 32'(ma_fs));
  endtask

  task automatic check_b();
    check("b_hcount", 32'(b_h), mb_h);
    check("b_vcount", 32'(b_v), mb_v);
    check("b_hsync", 32'(b_hs), (mb_h >= 10 && mb_h < 13) ? 1 : 0);
    check("b_vsync", 32'(b_vs), (mb_v >= 7 && mb_v < 9) ? 0 : 1);
    check("b_hblank", 32'(b_hb), (mb_h >= 8) ? 1 : 0);
    check("b_vblank", 32'(b_vb), (mb_v >= 6) ? 1 : 0);
    check("b_de", 32'(b_de), (mb_h < 8 && mb_v < 6) ? 1 : 0);
    check("b_line_start", 32'(b_ls), 32'(mb_ls));
    check("b_frame_start", 32'(b_fs), 32'(mb_fs));
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("b_frame_count", 32'(b_fc), mb_fc);
`endif
  endtask

  task automatic step_a(input bit ce);
    ce_a = ce;
    ce_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (ce) begin
      ma_ls = (ma_h == 799);
      ma_fs = ma_ls && (ma_v == 524);
      if (ma_ls) begin
        ma_h = 0;
        ma_v = (ma_v == 524) ? 0 : ma_v + 1;
      end else begin
        ma_h++;
      end
    end else begin
      ma_ls = 1'b0;
      ma_fs = 1'b0;
    end
    check_a();
  endtask

  task automatic step_b(input bit ce);
    ce_a = 1'b0;
    ce_b = ce;
    @(posedge clk);
    @(negedge clk);
    if (ce) begin
      mb_ls = (mb_h == 15);
      mb_fs = mb_ls && (mb_v == 9);
      if (mb_ls) begin
        mb_h = 0;
        mb_v = (mb_v == 9) ? 0 : mb_v + 1;
      end else begin
        mb_h++;
      end
      if (mb_fs) mb_fc = (mb_fc + 1) % 256;
    end else begin
      mb_ls = 1'b0;
      mb_fs = 1'b0;
    end
    check_b();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce_a  = 1'b1;
    ce_b  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ma_h = 0; ma_v = 0; ma_ls = 1'b0; ma_fs = 1'b0;
    mb_h = 0; mb_v = 0; mb_ls = 1'b0; mb_fs = 1'b0; mb_fc = 0;
    check_a();
    check_b();
  endtask

  initial begin
    int ls_cnt, hb_first, hs_low, hs_first, fs_cnt, last_fs;
    reset = 1'b1;
    ce_a  = 1'b1;
    ce_b  = 1'b1;
    @(posedge clk);
    do_reset();

    // Full line at one pixel per clk
    ls_cnt = 0;
    hb_first = -1;
    for (int i = 0; i < 800; i++) begin
      step_a(1'b1);
      if (a_ls) ls_cnt++;
      if (a_hb && hb_first < 0) hb_first = int'(a_h);
    end
    check("line_end_h", 32'(a_h), 0);
    check("line_end_v", 32'(a_v), 1);
    check("line_start_count", ls_cnt, 1);
    check("hblank_rise_h", hb_first, 640);

    // Half-rate ce_pix across one line
    hs_low = 0;
    hs_first = -1;
    for (int i = 0; i < 800; i++) begin
      step_a(1'b1);
      if (!a_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(a_h);
      end
      step_a(1'b0);
      if (!a_hs) hs_low++;
    end
    check("hsync_low_clks", hs_low, 192);
    check("hsync_first_low_h", hs_first, 656);
    check("half_rate_end_v", 32'(a_v), 2);

    // Stall at hcount 300
    for (int i = 0; i < 300; i++) step_a(1'b1);
    check("stall_at_h", 32'(a_h), 300);
    for (int i = 0; i < 100; i++) step_a(1'b0);
    step_a(1'b1);
    check("stall_resume_h", 32'(a_h), 301);

    // Mid-line reset with ce_pix high in the same cycle
    do_reset();
    check("rst_mid_h", 32'(a_h), 0);
    check("rst_mid_de", 32'(a_de), 1);
    check("rst_mid_hsync", 32'(a_hs), 1);
    check("rst_mid_ls", 32'(a_ls), 0);
    step_a(1'b1);

    // Small raster: reset inside the frame, then 256 whole frames
    for (int i = 0; i < 53; i++) step_b(1'b1);
    check("b_mid_h", 32'(b_h), 5);
    check("b_mid_v", 32'(b_v), 3);
    do_reset();
    check("b_rst_hsync", 32'(b_hs), 0);
    check("b_rst_vsync", 32'(b_vs), 1);
    fs_cnt = 0;
    last_fs = 0;
    for (int cyc = 1; cyc <= 256 * 160; cyc++) begin
      step_b(1'b1);
      if (b_fs) begin
        check("b_fs_period", cyc - last_fs, 160);
        last_fs = cyc;
        fs_cnt++;
      end
`ifdef VGA_TIMING_FRAME_COUNT_EN
      if (cyc == 255 * 160) check("b_fc_255", 32'(b_fc), 255);
`endif
    end
    check("b_fs_count", fs_cnt, 256);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    check("b_fc_wrap", 32'(b_fc), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates raster timing for the game core.
- Sits directly upstream of the mist_video scaler/OSD stage and supplies the HSync, VSync, HBlank and VBlank inputs it consumes.
- Exports pixel and line coordinates so the game renderer can produce 1-bit R/G/B aligned to the same cycle.
- Runs on the system clock, with a pixel clock-enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous, active-high
- ce_pix, input, 1, pixel enable; counters advance only on cycles where it is 1
- hcount, output, 10, current pixel column, 0..H_TOTAL-1
- vcount, output, 10, current line, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync at HS_POL level while active
- vsync, output, 1, vertical sync at VS_POL level while active
- hblank, output, 1, high outside the active columns
- vblank, output, 1, high outside the active lines
- de, output, 1, high when ~hblank & ~vblank
- line_start, output, 1, one-clk pulse when hcount becomes 0
- frame_start, output, 1, one-clk pulse when (hcount,vcount) becomes (0,0)

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both must be ≤1024; elaboration fails otherwise.
- Register model: every output is a register. Sync, blank and de outputs are decoded from the next count values, so in any cycle all outputs describe the same (hcount,vcount).
- Reset (reset=1 at a clk edge; takes priority over ce_pix):
  - hcount=0, vcount=0.
  - hblank=0, vblank=0, de=1.
  - hsync=~HS_POL, vsync=~VS_POL.
  - line_start=0, frame_start=0.
- ce_pix=1, no reset:
  - hcount increments.
  - When hcount==H_TOTAL-1 it wraps to 0 and vcount increments.
  - When vcount==V_TOTAL-1 at that same wrap, vcount wraps to 0.
- ce_pix=0: counters and all level outputs hold. line_start and frame_start clear to 0 on the next clk.
- Decodes (h = hcount, v = vcount):
  - hblank = (h ≥ H_ACTIVE).
  - vblank = (v ≥ V_ACTIVE).
  - hsync active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. vsync changes only at h=0.
- Pulses:
  - line_start=1 for exactly one clk, in the cycle whose hcount is 0 following a ce_pix wrap.
  - frame_start additionally requires vcount=0.
  - The 0,0 state produced by reset does not pulse either signal.
- Latency: one clk from a ce_pix edge to the updated counts and decodes. There is no combinational path from ce_pix to any output.
- ce_pix may be held high continuously, giving one pixel per clk. Irregular ce_pix patterns stretch time but never skip or duplicate a count.
- Reset mid-frame: the next cycle is (0,0) with reset values. There is no partial line or pulse.

Optional Feature:
- Macro: VGA_TIMING_FRAME_COUNT_EN
- When defined:
  - Adds output frame_count[7:0], reset to 0.
  - Increments by 1 (mod 256) in the same cycle frame_start pulses. This gives the game core an animation tick without a separate divider.
- When undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Line length: reset, then ce_pix=1 continuously for 800 clks → hcount back to 0, vcount=1, line_start pulses once, hblank rises at hcount=640.
- Hsync: defaults, ce_pix toggling 1/0 → hsync low exactly at hcount 656..751 (96 ce pulses = 192 clks), high elsewhere.
- Frame: ce_pix=1 → vsync low only on lines 490–491 (1600 clks); vblank high for lines 480..524; frame_start pulses every 420000 clks, with no pulse at reset.
- Stall: ce_pix=0 for 100 clks at hcount=300 → all outputs frozen; line_start and frame_start stay 0; counting resumes at 301.
- Reset mid-frame: assert reset at hcount=300, vcount=200, with ce_pix=1 in the same cycle → next cycle hcount=0, vcount=0, de=1, sync outputs inactive, no pulses.
- VGA_TIMING_FRAME_COUNT_EN: run 256 frames → frame_count steps 0→255 and then wraps to 0 on the 256th frame_start.
